// File: rtl/epu_sram_arbiter_if.sv
// Requester-side bundle for epu_sram_arbiter: AXI side (a_*) and CONV engine (c_*).
interface epu_sram_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [STRB_W-1:0] a_wstrb;
  logic              a_gnt;
  logic              a_rvalid;

  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [STRB_W-1:0] c_wstrb;
  logic              c_gnt;
  logic              c_rvalid;

  modport master (
    output a_req, a_we, a_addr, a_wdata, a_wstrb,
    output c_req, c_we, c_addr, c_wdata, c_wstrb,
    input  a_gnt, a_rvalid, c_gnt, c_rvalid
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, a_wstrb,
    input  c_req, c_we, c_addr, c_wdata, c_wstrb,
    output a_gnt, a_rvalid, c_gnt, c_rvalid
  );
endinterface

// File: rtl/epu_sram_arbiter.sv
// Two-requester arbiter for one single-port EPU buffer SRAM bank.
// Burst-friendly ownership (OWN_A / OWN_C) with a MAX_GRANT fairness cap and
// round-robin tie-break. Define EPU_ARB_FIXED_PRIO_EN for fixed priority to CONV.
module epu_sram_arbiter #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_GRANT = 16
) (
  input  logic                clk,
  input  logic                rst,
  epu_sram_arbiter_if.slave   req_if,
  output logic                mem_cs,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                busy_o
);
  localparam int unsigned      CNT_W   = $clog2(MAX_GRANT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_GRANT);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN_A = 2'd1, OWN_C = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifndef EPU_ARB_FIXED_PRIO_EN
  logic              last_c_q, last_c_d;
`endif
  logic              a_rvalid_q, c_rvalid_q;
  logic [ADDR_W-1:0] addr_hold_q;
  logic [DATA_W-1:0] wdata_hold_q;
  logic              a_gnt, c_gnt, at_cap, a_block, c_block;

  // State, grant counter, tie-break history and read-valid tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
`ifndef EPU_ARB_FIXED_PRIO_EN
      last_c_q   <= 1'b1;
`endif
      a_rvalid_q <= 1'b0;
      c_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
`ifndef EPU_ARB_FIXED_PRIO_EN
      last_c_q   <= last_c_d;
`endif
      a_rvalid_q <= a_gnt & ~req_if.a_we;
      c_rvalid_q <= c_gnt & ~req_if.c_we;
    end
  end

  // Last granted address/data, held on the macro pins between accesses.
  always_ff @(posedge clk) begin
    if (a_gnt) begin
      addr_hold_q  <= req_if.a_addr;
      wdata_hold_q <= req_if.a_wdata;
    end else if (c_gnt) begin
      addr_hold_q  <= req_if.c_addr;
      wdata_hold_q <= req_if.c_wdata;
    end
  end

  // Ownership transitions; counter restarts on every ownership change.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
`ifndef EPU_ARB_FIXED_PRIO_EN
    last_c_d = last_c_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_if.a_req && req_if.c_req) begin
`ifdef EPU_ARB_FIXED_PRIO_EN
          state_d = OWN_C;
`else
          state_d = last_c_q ? OWN_A : OWN_C;
`endif
        end else if (req_if.a_req) begin
          state_d = OWN_A;
        end else if (req_if.c_req) begin
          state_d = OWN_C;
        end
      end
      OWN_A: begin
        if (!req_if.a_req)  state_d = req_if.c_req ? OWN_C : IDLE;
        else if (a_block)   state_d = OWN_C;
      end
      OWN_C: begin
        if (!req_if.c_req)  state_d = req_if.a_req ? OWN_A : IDLE;
        else if (c_block)   state_d = OWN_A;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
`ifndef EPU_ARB_FIXED_PRIO_EN
      if (state_d == OWN_A)      last_c_d = 1'b0;
      else if (state_d == OWN_C) last_c_d = 1'b1;
`endif
    end else if ((a_gnt || c_gnt) && !at_cap) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Grants and SRAM pin mux; a blocked owner yields for one handoff cycle.
  always_comb begin
    at_cap = (cnt_q == CNT_MAX);
`ifdef EPU_ARB_FIXED_PRIO_EN
    a_block = req_if.c_req;
    c_block = 1'b0;
`else
    a_block = at_cap & req_if.c_req;
    c_block = at_cap & req_if.a_req;
`endif
    a_gnt     = ~rst & (state_q == OWN_A) & req_if.a_req & ~a_block;
    c_gnt     = ~rst & (state_q == OWN_C) & req_if.c_req & ~c_block;
    mem_cs    = a_gnt | c_gnt;
    mem_we    = '0;
    mem_addr  = addr_hold_q;
    mem_wdata = wdata_hold_q;
    if (a_gnt) begin
      mem_addr  = req_if.a_addr;
      mem_wdata = req_if.a_wdata;
      if (req_if.a_we) mem_we = req_if.a_wstrb;
    end else if (c_gnt) begin
      mem_addr  = req_if.c_addr;
      mem_wdata = req_if.c_wdata;
      if (req_if.c_we) mem_we = req_if.c_wstrb;
    end
    busy_o = (state_q != IDLE);
  end

  assign req_if.a_gnt    = a_gnt;
  assign req_if.c_gnt    = c_gnt;
  assign req_if.a_rvalid = a_rvalid_q;
  assign req_if.c_rvalid = c_rvalid_q;
  assign rdata_o         = mem_rdata;
endmodule

// File: tb/tb_epu_sram_arbiter.sv
// Self-checking bench for epu_sram_arbiter: directed scenarios plus random traffic
// against an ownership/run-length reference model and a golden memory image.
module tb_epu_sram_arbiter;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MAX_GRANT = 4;
  localparam int          MAX_G     = int'(MAX_GRANT);
`ifdef EPU_ARB_FIXED_PRIO_EN
  localparam bit          FIXED     = 1'b1;
  localparam logic [1:0]  TIE_EXP   = 2'b01;
`else
  localparam bit          FIXED     = 1'b0;
  localparam logic [1:0]  TIE_EXP   = 2'b10;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_cs;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] rdata_o;
  logic              busy_o;

  always #5 clk = ~clk;

  epu_sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  epu_sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_GRANT(MAX_GRANT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_if    (bus.slave),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rdata_o   (rdata_o),
    .busy_o    (busy_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sram [256];
  logic [31:0] gmem [256];

  // reference model: owner 0=none 1=A 2=C, run = grants since ownership began
  int          m_owner, m_run, m_last;
  bit          m_rva, m_rvc, m_lga, m_lgc, m_hold_ok;
  logic [31:0] m_rdexp, m_hold_wd;
  logic [15:0] m_hold_addr;

  bit          s_ga, s_gc, s_cs, s_busy, s_arv, s_crv;
  logic [31:0] s_rdata;
  logic [15:0] s_maddr;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h required 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_a(input logic req, input logic we, input int unsigned addr,
                         input logic [31:0] wd, input logic [3:0] st);
    bus.a_req = req; bus.a_we = we; bus.a_addr = ADDR_W'(addr);
    bus.a_wdata = wd; bus.a_wstrb = st;
  endtask

  task automatic drive_c(input logic req, input logic we, input int unsigned addr,
                         input logic [31:0] wd, input logic [3:0] st);
    bus.c_req = req; bus.c_we = we; bus.c_addr = ADDR_W'(addr);
    bus.c_wdata = wd; bus.c_wstrb = st;
  endtask

  // One clock: check DUT at negedge, advance model and SRAM, return at posedge+1.
  task automatic step();
    bit          ga, gc, rd_pend;
    int          nxt;
    logic [3:0]  ewe;
    logic [15:0] eaddr;
    logic [31:0] ewd, rd_next;
    @(negedge clk);
    ga = 1'b0; gc = 1'b0;
    if (!rst) begin
      if (m_owner == 1 && bus.a_req) ga = FIXED ? !bus.c_req : !(m_run == MAX_G && bus.c_req);
      if (m_owner == 2 && bus.c_req) gc = FIXED ? 1'b1 : !(m_run == MAX_G && bus.a_req);
    end
    eaddr = ga ? bus.a_addr  : bus.c_addr;
    ewd   = ga ? bus.a_wdata : bus.c_wdata;
    ewe   = 4'h0;
    if (ga && bus.a_we) ewe = bus.a_wstrb;
    if (gc && bus.c_we) ewe = bus.c_wstrb;

    check_eq("a_gnt", bus.a_gnt, ga);
    check_eq("c_gnt", bus.c_gnt, gc);
    check_eq("mem_cs", mem_cs, ga | gc);
    check_eq("mem_we", mem_we, ewe);
    check_eq("busy_o", busy_o, m_owner != 0);
    check_eq("a_rvalid", bus.a_rvalid, m_rva);
    check_eq("c_rvalid", bus.c_rvalid, m_rvc);
    if (ga || gc) begin
      check_eq("mem_addr", mem_addr, eaddr);
      check_eq("mem_wdata", mem_wdata, ewd);
    end else if (m_hold_ok) begin
      check_eq("mem_addr_hold", mem_addr, m_hold_addr);
      check_eq("mem_wdata_hold", mem_wdata, m_hold_wd);
    end
    if (m_rva || m_rvc) check_eq("rdata_o", rdata_o, m_rdexp);

    s_ga = bus.a_gnt; s_gc = bus.c_gnt; s_cs = mem_cs; s_busy = busy_o;
    s_arv = bus.a_rvalid; s_crv = bus.c_rvalid; s_rdata = rdata_o; s_maddr = mem_addr;

    // SRAM macro behaviour, driven by what the DUT actually put on the pins
    rd_pend = 1'b0; rd_next = '0;
    if (mem_cs) begin
      if (mem_we == 4'h0) begin
        rd_pend = 1'b1; rd_next = sram[mem_addr[7:0]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) sram[mem_addr[7:0]][8*b +: 8] = mem_wdata[8*b +: 8];
      end
    end

    // golden memory and read expectation
    m_rva = ga && !bus.a_we;
    m_rvc = gc && !bus.c_we;
    if (m_rva || m_rvc) m_rdexp = gmem[eaddr[7:0]];
    for (int b = 0; b < 4; b++)
      if (ewe[b]) gmem[eaddr[7:0]][8*b +: 8] = ewd[8*b +: 8];
    if (ga || gc) begin
      m_hold_ok = 1'b1; m_hold_addr = eaddr; m_hold_wd = ewd;
    end
    m_lga = ga; m_lgc = gc;

    if (rst) begin
      m_owner = 0; m_run = 0; m_last = 2; m_rva = 1'b0; m_rvc = 1'b0;
    end else begin
      nxt = m_owner;
      case (m_owner)
        0: if (bus.a_req && bus.c_req) nxt = FIXED ? 2 : (m_last == 2 ? 1 : 2);
           else if (bus.a_req) nxt = 1;
           else if (bus.c_req) nxt = 2;
        1: if (!bus.a_req) nxt = bus.c_req ? 2 : 0;
           else if (bus.c_req && (FIXED || m_run == MAX_G)) nxt = 2;
        default: if (!bus.c_req) nxt = bus.a_req ? 1 : 0;
           else if (bus.a_req && !FIXED && m_run == MAX_G) nxt = 1;
      endcase
      if (nxt != m_owner) begin
        m_run = 0;
        if (nxt != 0) m_last = nxt;
      end else if ((ga || gc) && m_run < MAX_G) begin
        m_run++;
      end
      m_owner = nxt;
    end

    @(posedge clk);
    #1;
    if (rd_pend) mem_rdata = rd_next;
  endtask

  initial begin
    int n, nc, first;
    logic [31:0] v;
    rst = 1'b1;
    mem_rdata = '0;
    drive_a(1'b0, 1'b0, 0, '0, '0);
    drive_c(1'b0, 1'b0, 0, '0, '0);
    for (int i = 0; i < 256; i++) begin
      v = $urandom; sram[i] = v; gmem[i] = v;
    end
    sram[8'h20] = 32'hDEADBEEF; gmem[8'h20] = 32'hDEADBEEF;
    m_owner = 0; m_run = 0; m_last = 2; m_rva = 1'b0; m_rvc = 1'b0;
    m_lga = 1'b0; m_lgc = 1'b0; m_hold_ok = 1'b0; m_rdexp = '0;
    m_hold_addr = '0; m_hold_wd = '0;

    // reset with both requesting a read of 0x20, then tie-break and read data
    drive_a(1'b1, 1'b0, 'h20, '0, '0);
    drive_c(1'b1, 1'b0, 'h20, '0, '0);
    @(posedge clk); #1;
    step();
    check_eq("rst_outputs", {s_ga, s_gc, s_cs, s_arv, s_crv}, 5'b0);
    check_eq("rst_busy", s_busy, 1'b0);
    rst = 1'b0;
    step();
    check_eq("idle_no_gnt", {s_ga, s_gc}, 2'b00);
    step();
    check_eq("tie_winner", {s_ga, s_gc}, TIE_EXP);
    drive_a(1'b0, 1'b0, 0, '0, '0);
    drive_c(1'b0, 1'b0, 0, '0, '0);
    step();
    check_eq("tie_rvalid", {s_arv, s_crv}, TIE_EXP);
    check_eq("tie_rdata", s_rdata, 32'hDEADBEEF);
    step();

    // A-only write burst 0x10..0x13
    drive_a(1'b1, 1'b1, 'h10, 32'hA0, 4'hF);
    n = 0; first = -1;
    for (int i = 0; i < 12 && n < 4; i++) begin
      step();
      if (s_ga) begin
        if (first < 0) first = i;
        check_eq("wr_addr", s_maddr, 'h10 + n);
        n++;
        if (n < 4) drive_a(1'b1, 1'b1, 'h10 + n, 32'hA0 + n, 4'hF);
        else       drive_a(1'b0, 1'b0, 0, '0, '0);
      end
    end
    check_eq("wr_burst_len", n, 4);
    check_eq("wr_first_gnt_cycle", first, 1);
    step(); step();
    check_eq("wr_back_idle", s_busy, 1'b0);

`ifndef EPU_ARB_FIXED_PRIO_EN
    // fairness cap: A continuous, C raised during A's first grant
    drive_a(1'b1, 1'b0, 'h40, '0, '0);
    step();
    drive_c(1'b1, 1'b0, 'h41, '0, '0);
    n = 0; first = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (s_gc) break;
      if (s_ga) n++; else first++;
    end
    check_eq("cap_a_grants", n, MAX_G);
    check_eq("cap_gap_cycles", first, 1);
    nc = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (s_ga) break;
      if (s_gc) nc++;
    end
    check_eq("cap_c_grants", nc, MAX_G);
    drive_a(1'b0, 1'b0, 0, '0, '0);
    drive_c(1'b0, 1'b0, 0, '0, '0);
    step(); step();

    // direct handoff: C waiting, A drops after 2 grants
    drive_a(1'b1, 1'b1, 'h50, 32'h1234_5678, 4'h3);
    step();
    drive_c(1'b1, 1'b1, 'h51, 32'h8765_4321, 4'hC);
    step(); check_eq("ho_a_gnt1", s_ga, 1'b1);
    step(); check_eq("ho_a_gnt2", s_ga, 1'b1);
    drive_a(1'b0, 1'b0, 0, '0, '0);
    step();
    check_eq("ho_gap", {s_ga, s_gc}, 2'b00);
    check_eq("ho_busy_gap", s_busy, 1'b1);
    step();
    check_eq("ho_c_gnt", s_gc, 1'b1);
    check_eq("ho_busy_c", s_busy, 1'b1);
    drive_c(1'b0, 1'b0, 0, '0, '0);
    step(); step();
`else
    // fixed priority: C preempts A's 10-word burst at its 3rd grant
    drive_a(1'b1, 1'b1, 'h60, 32'hB0, 4'hF);
    n = 0;
    step();
    for (int i = 0; i < 6 && n < 2; i++) begin
      step();
      if (s_ga) begin n++; drive_a(1'b1, 1'b1, 'h60 + n, 32'hB0 + n, 4'hF); end
    end
    drive_c(1'b1, 1'b0, 'h70, '0, '0);
    step();
    check_eq("prio_a_blocked", s_ga, 1'b0);
    nc = 0;
    for (int i = 0; i < 20; i++) begin step(); if (s_gc) nc++; end
    check_eq("prio_c_hold", nc, 20);
    drive_c(1'b0, 1'b0, 0, '0, '0);
    step();
    step();
    check_eq("prio_a_resume", s_ga, 1'b1);
    if (s_ga) begin n++; drive_a(1'b1, 1'b1, 'h60 + n, 32'hB0 + n, 4'hF); end
    for (int i = 0; i < 20 && n < 10; i++) begin
      step();
      if (s_ga) begin
        n++;
        if (n < 10) drive_a(1'b1, 1'b1, 'h60 + n, 32'hB0 + n, 4'hF);
        else        drive_a(1'b0, 1'b0, 0, '0, '0);
      end
    end
    check_eq("prio_a_burst_len", n, 10);
    step(); step();
`endif

    // random traffic with occasional mid-burst reset
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 249) == 0);
      if (m_lga || !bus.a_req) begin
        if ($urandom_range(0, 3) != 0)
          drive_a(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom,
                  4'($urandom_range(1, 15)));
        else bus.a_req = 1'b0;
      end
      if (m_lgc || !bus.c_req) begin
        if ($urandom_range(0, 3) != 0)
          drive_c(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom,
                  4'($urandom_range(1, 15)));
        else bus.c_req = 1'b0;
      end
      step();
    end
    rst = 1'b0;
    drive_a(1'b0, 1'b0, 0, '0, '0);
    drive_c(1'b0, 1'b0, 0, '0, '0);
    step(); step(); step();
    check_eq("final_idle", s_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
